// File: rtl/seq_cover_monitor.sv
// seq_cover_monitor: per-channel runtime checker for the sequence
//   x ##D1 y[*MIN_REP:MAX_REP] ##D2 z
// Each channel runs one attempt at a time. It reports match/fail pulses and
// keeps saturating match/fail counters.
module seq_cover_monitor #(
  parameter int NCH     = 4,
  parameter int D1      = 2,
  parameter int MIN_REP = 3,
  parameter int MAX_REP = 4,
  parameter int D2      = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic [NCH-1:0]     en_i,
  input  logic [NCH-1:0]     x_i,
  input  logic [NCH-1:0]     y_i,
  input  logic [NCH-1:0]     z_i,
  output logic [NCH-1:0]     busy_o,
  output logic [NCH-1:0]     match_o,
  output logic [NCH-1:0]     fail_o,
  output logic [NCH*CNT_W-1:0] match_cnt_o,
  output logic [NCH*CNT_W-1:0] fail_cnt_o
);

  // Illegal parameter combinations stop elaboration.
  if (D1 < 1)            begin : g_bad_d1  $error("seq_cover_monitor: D1 must be >= 1"); end
  if (D2 < 1)            begin : g_bad_d2  $error("seq_cover_monitor: D2 must be >= 1"); end
  if (MIN_REP < 1)       begin : g_bad_min $error("seq_cover_monitor: MIN_REP must be >= 1"); end
  if (MAX_REP < MIN_REP) begin : g_bad_max $error("seq_cover_monitor: MAX_REP must be >= MIN_REP"); end

  // DLY1 counts edges 0 .. D1-2. The run counter must be able to hold MAX_REP.
  localparam int DC_W = (D1 > 2) ? $clog2(D1) : 1;
  localparam int RC_W = $clog2(MAX_REP + 1);

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(D1 - 2);
  localparam logic [RC_W-1:0] MIN_R   = RC_W'(MIN_REP);
  localparam logic [RC_W-1:0] MAX_R   = RC_W'(MAX_REP);
  localparam logic [D2-1:0]   PEND_NEW = D2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DLY1  = 2'd1,
    REP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Saturating increment: the counter holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t            r_state, w_state_nxt;
    logic [DC_W-1:0]   r_dcnt, w_dcnt_nxt;
    logic [RC_W-1:0]   r_run, w_run_nxt, w_run_inc;
    logic [D2-1:0]     r_pend, w_pend_nxt, w_pend_sh;
    logic              r_match, r_fail, w_match, w_fail, w_end, w_zhit;
    logic [CNT_W-1:0]  r_mcnt, r_fcnt;

    // Next-state logic: decide match/fail, schedule z checks, start/abort attempts.
    always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_run_nxt   = r_run;
      w_pend_nxt  = r_pend;
      w_match     = 1'b0;
      w_fail      = 1'b0;
      w_end       = 1'b0;
      w_run_inc   = r_run + 1'b1;
      w_pend_sh   = r_pend << 1;
      // Oldest pending check is due this edge.
      w_zhit      = r_pend[D2-1] & z_i[c];

      case (r_state)
        IDLE: ;
        DLY1: begin
          if (r_dcnt == DC_LAST) w_state_nxt = REP;
          else                   w_dcnt_nxt  = r_dcnt + 1'b1;
        end
        REP: begin
          w_pend_nxt = w_pend_sh;
          if (w_zhit) begin
            w_match = 1'b1;
            w_end   = 1'b1;
          end else if (y_i[c]) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc >= MIN_R) w_pend_nxt  = w_pend_sh | PEND_NEW;
            if (w_run_inc == MAX_R) w_state_nxt = DRAIN;
          end else if (r_run < MIN_R) begin
            w_fail = 1'b1;
            w_end  = 1'b1;
          end else if (w_pend_sh == '0) begin
            w_fail = 1'b1;
            w_end  = 1'b1;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          w_pend_nxt = w_pend_sh;
          if (w_zhit) begin
            w_match = 1'b1;
            w_end   = 1'b1;
          end else if (w_pend_sh == '0) begin
            w_fail = 1'b1;
            w_end  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase

      if (w_end) begin
        w_state_nxt = IDLE;
        w_pend_nxt  = '0;
      end

      // A new attempt may begin on the same edge that the previous one is decided.
      if ((r_state == IDLE || w_end) && x_i[c]) begin
        w_state_nxt = (D1 == 1) ? REP : DLY1;
        w_dcnt_nxt  = '0;
        w_run_nxt   = '0;
        w_pend_nxt  = '0;
      end

      // Disable and clear both abort silently and block new attempts.
      if (!en_i[c] || clr_i) begin
        w_state_nxt = IDLE;
        w_pend_nxt  = '0;
        w_match     = 1'b0;
        w_fail      = 1'b0;
      end
    end

    // State, pulse and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_dcnt  <= '0;
        r_run   <= '0;
        r_pend  <= '0;
        r_match <= 1'b0;
        r_fail  <= 1'b0;
        r_mcnt  <= '0;
        r_fcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_dcnt  <= w_dcnt_nxt;
        r_run   <= w_run_nxt;
        r_pend  <= w_pend_nxt;
        r_match <= w_match;
        r_fail  <= w_fail;
        if (clr_i) begin
          r_mcnt <= '0;
          r_fcnt <= '0;
        end else begin
          if (w_match) r_mcnt <= sat_inc(r_mcnt);
          if (w_fail)  r_fcnt <= sat_inc(r_fcnt);
        end
      end
    end

    assign busy_o[c]                       = (r_state != IDLE);
    assign match_o[c]                      = r_match;
    assign fail_o[c]                       = r_fail;
    assign match_cnt_o[c*CNT_W +: CNT_W]   = r_mcnt;
    assign fail_cnt_o[c*CNT_W +: CNT_W]    = r_fcnt;
  end

endmodule

// File: tb/tb_seq_cover_monitor.sv
// Directed bench for seq_cover_monitor (D1=2, MIN_REP=3, MAX_REP=4, D2=1,
// NCH=4, CNT_W=2 so that counter saturation is reachable).
module tb_seq_cover_monitor;
  localparam int NCH   = 4;
  localparam int CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr_i = 1'b0;
  logic [NCH-1:0]       en_i = '1;
  logic [NCH-1:0]       x_i = '0;
  logic [NCH-1:0]       y_i = '0;
  logic [NCH-1:0]       z_i = '0;
  logic [NCH-1:0]       busy_o, match_o, fail_o;
  logic [NCH*CNT_W-1:0] match_cnt_o, fail_cnt_o;

  seq_cover_monitor #(
    .NCH(NCH), .D1(2), .MIN_REP(3), .MAX_REP(4), .D2(1), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .en_i(en_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .busy_o(busy_o), .match_o(match_o), .fail_o(fail_o),
    .match_cnt_o(match_cnt_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int mcnt(input int c);
    return int'(match_cnt_o[c*CNT_W +: CNT_W]);
  endfunction

  function automatic int fcnt(input int c);
    return int'(fail_cnt_o[c*CNT_W +: CNT_W]);
  endfunction

  // Per-run record: first match/fail cycle, pulse count, busy trace of channel 0.
  int mc [NCH];
  int fc [NCH];
  int np [NCH];
  int both;
  logic [16:0] bz0;

  // Cycle i inputs are sampled at edge i; an output seen after edge i is cycle i+1.
  // Vectors: channel c, cycle i at bit c*16+i.
  task automatic run(input logic [63:0] xv, input logic [63:0] yv, input logic [63:0] zv,
                     input int clr_cyc, input int enoff_ch, input int enoff_cyc,
                     input int ncyc);
    for (int c = 0; c < NCH; c++) begin
      mc[c] = -1; fc[c] = -1; np[c] = 0;
    end
    both = 0;
    bz0  = '0;
    for (int i = 0; i < ncyc; i++) begin
      for (int c = 0; c < NCH; c++) begin
        x_i[c]  = xv[c*16+i];
        y_i[c]  = yv[c*16+i];
        z_i[c]  = zv[c*16+i];
        en_i[c] = !(c == enoff_ch && i >= enoff_cyc);
      end
      clr_i = (i == clr_cyc);
      @(posedge clk); #1;
      bz0[i+1] = busy_o[0];
      for (int c = 0; c < NCH; c++) begin
        if (match_o[c]) begin np[c]++; if (mc[c] < 0) mc[c] = i + 1; end
        if (fail_o[c])  begin np[c]++; if (fc[c] < 0) fc[c] = i + 1; end
      end
      if (|(match_o & fail_o)) both++;
    end
    x_i = '0; y_i = '0; z_i = '0; clr_i = 1'b0; en_i = '1;
  endtask

  task automatic clear_all();
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
  endtask

  // Channel-0 patterns used repeatedly.
  localparam logic [63:0] X0   = 64'h1;
  localparam logic [63:0] Y234 = 64'h1C;
  localparam logic [63:0] Z5   = 64'h20;

  initial begin
    // Reset: hold with x high; nothing may start or pulse.
    x_i = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy_o), 0);
    chk("rst pulses", int'(match_o | fail_o), 0);
    chk("rst counts", int'(match_cnt_o | fail_cnt_o), 0);
    x_i = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: x@0 y@2,3,4 z@5 -> match cycle 6.
    run(X0, Y234, Z5, -1, -1, 99, 10);
    chk("t1 match cyc", mc[0], 6);
    chk("t1 no fail", fc[0], -1);
    chk("t1 pulses", np[0], 1);
    chk("t1 busy trace", int'(bz0), 'h3E);
    chk("t1 mcnt", mcnt(0), 1);
    chk("t1 fcnt", fcnt(0), 0);
    chk("t1 other ch quiet", np[1] + np[2] + np[3], 0);
    clear_all();
    chk("clr counts", mcnt(0), 0);

    // 2: y@2..5, z low @5, high @6 -> match via r=4, cycle 7.
    run(X0, 64'h3C, 64'h40, -1, -1, 99, 10);
    chk("t2 match cyc", mc[0], 7);
    chk("t2 no fail", fc[0], -1);

    // 3a: y@2,3 only -> fail cycle 5.
    run(X0, 64'h0C, 64'h0, -1, -1, 99, 10);
    chk("t3a fail cyc", fc[0], 5);
    chk("t3a no match", mc[0], -1);
    // 3b: y@2..6, z never -> fail cycle 7.
    run(X0, 64'h7C, 64'h0, -1, -1, 99, 10);
    chk("t3b fail cyc", fc[0], 7);
    chk("t3b no match", mc[0], -1);
    chk("t3 fcnt", fcnt(0), 2);
    chk("t3 mcnt", mcnt(0), 1);
    clear_all();

    // 4: x@0,1 -> one attempt; x@5 on deciding edge starts another (y@7,8,9 z@10).
    run(64'h23, 64'h39C, 64'h420, -1, -1, 99, 14);
    chk("t4 first match", mc[0], 6);
    chk("t4 pulses", np[0], 2);
    chk("t4 no fail", fc[0], -1);
    chk("t4 mcnt", mcnt(0), 2);
    clear_all();

    // Independence: ch1 match pattern, ch2 short-run fail, ch3 aborted by en low @3.
    run((X0 << 16) | (X0 << 32) | (X0 << 48),
        (Y234 << 16) | (64'h0C << 32) | (Y234 << 48),
        (Z5 << 16) | (Z5 << 48), -1, 3, 3, 10);
    chk("ind ch1 match", mc[1], 6);
    chk("ind ch2 fail", fc[2], 5);
    chk("ind ch2 no match", mc[2], -1);
    chk("ind ch0 quiet", np[0], 0);
    chk("ind ch3 aborted", np[3], 0);
    chk("ind ch3 counts", mcnt(3) + fcnt(3), 0);
    chk("ind ch1 mcnt", mcnt(1), 1);
    chk("ind ch2 fcnt", fcnt(2), 1);
    chk("ind never both", both, 0);
    clear_all();

    // 5: saturation at 3 with CNT_W=2, then clear.
    for (int k = 0; k < 5; k++) run(X0, Y234, Z5, -1, -1, 99, 8);
    chk("sat mcnt", mcnt(0), 3);
    clear_all();
    chk("sat clr", mcnt(0), 0);

    // clr at cycle 3 mid-attempt -> no pulse, channel idle.
    run(X0, Y234, Z5, 3, -1, 99, 10);
    chk("clr mid pulses", np[0], 0);
    chk("clr mid busy", int'(bz0), 'h0E);
    chk("clr mid mcnt", mcnt(0), 0);

    // Asynchronous reset mid-attempt clears outputs without a clock edge.
    run(X0, Y234, Z5, -1, -1, 99, 8);
    x_i[0] = 1'b1;
    @(posedge clk); #1;
    x_i[0] = 1'b0;
    @(posedge clk); #1;
    chk("arst pre busy", int'(busy_o[0]), 1);
    chk("arst pre mcnt", mcnt(0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", int'(busy_o), 0);
    chk("arst mcnt", mcnt(0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(X0, Y234, Z5, -1, -1, 99, 10);
    chk("post rst match", mc[0], 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
